// File: rtl/ssd1306_pkg.sv
// Shared constants for the emulated SSD1306 SPI front end: geometry, opcodes,
// addressing modes, command FSM states and reset defaults.
package ssd1306_pkg;

    localparam int unsigned X_SIZE    = 128;
    localparam int unsigned PAGES     = 8;
    localparam int unsigned COL_W     = 7;
    localparam int unsigned PAGE_W    = 3;
    localparam int unsigned FB_ADDR_W = 10;
    localparam int unsigned BYTE_W    = 8;

    typedef enum logic [1:0] {
        MODE_HORIZ = 2'd0,
        MODE_VERT  = 2'd1,
        MODE_PAGE  = 2'd2
    } addr_mode_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARG1  = 2'd1,
        ST_ARG2  = 2'd2,
        ST_SKIP1 = 2'd3
    } cmd_state_t;

    localparam logic [7:0] OP_DISP_OFF  = 8'hAE;
    localparam logic [7:0] OP_DISP_ON   = 8'hAF;
    localparam logic [7:0] OP_INV_OFF   = 8'hA6;
    localparam logic [7:0] OP_INV_ON    = 8'hA7;
    localparam logic [7:0] OP_SEG_0     = 8'hA0;
    localparam logic [7:0] OP_SEG_1     = 8'hA1;
    localparam logic [7:0] OP_COM_0     = 8'hC0;
    localparam logic [7:0] OP_COM_1     = 8'hC8;
    localparam logic [7:0] OP_CONTRAST  = 8'h81;
    localparam logic [7:0] OP_MODE      = 8'h20;
    localparam logic [7:0] OP_COL_ADDR  = 8'h21;
    localparam logic [7:0] OP_PAGE_ADDR = 8'h22;
    localparam logic [7:0] OP_CHARGE    = 8'h8D;
    localparam logic [7:0] OP_MUX       = 8'hA8;
    localparam logic [7:0] OP_OFFSET    = 8'hD3;
    localparam logic [7:0] OP_CLKDIV    = 8'hD5;
    localparam logic [7:0] OP_PRECHG    = 8'hD9;
    localparam logic [7:0] OP_COMPINS   = 8'hDA;
    localparam logic [7:0] OP_VCOMH     = 8'hDB;

    localparam logic [BYTE_W-1:0] CONTRAST_RST = 8'h7F;
    localparam logic [COL_W-1:0]  COL_MAX      = COL_W'(X_SIZE - 1);
    localparam logic [PAGE_W-1:0] PAGE_MAX     = PAGE_W'(PAGES - 1);

endpackage

// File: rtl/ssd1306_spi_rx.sv
// SPI mode-0 byte receiver: synchronises the MCU pins into sys_clk, detects
// scl rising edges and assembles MSB-first bytes tagged with dc.
module ssd1306_spi_rx
    import ssd1306_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              sys_clk,
    input  logic              rst,
    input  logic              ss_n,
    input  logic              scl,
    input  logic              mosi,
    input  logic              dc,
    input  logic              oled_rst_n,
    output logic              panel_rst,
    output logic              byte_valid,
    output logic [BYTE_W-1:0] rx_byte,
    output logic              byte_dc
);

    logic [SYNC_STAGES-1:0] ss_n_sync;
    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic [SYNC_STAGES-1:0] dc_sync;
    logic [SYNC_STAGES-1:0] prst_sync;
    logic                   scl_prev;
    logic [2:0]             bitcnt;
    logic [BYTE_W-2:0]      shift;
    logic                   ss_n_s;
    logic                   scl_s;
    logic                   mosi_s;
    logic                   dc_s;
    logic                   scl_rise;

    assign ss_n_s    = ss_n_sync[SYNC_STAGES-1];
    assign scl_s     = scl_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign dc_s      = dc_sync[SYNC_STAGES-1];
    assign panel_rst = ~prst_sync[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_prev & ~ss_n_s;

    // Synchronisers share one depth so mosi/dc are aligned with the scl edge.
    always_ff @(posedge sys_clk) begin
        if (!rst) begin
            ss_n_sync <= '1;
            scl_sync  <= '0;
            mosi_sync <= '0;
            dc_sync   <= '0;
            prst_sync <= '1;
        end else begin
            ss_n_sync <= {ss_n_sync[SYNC_STAGES-2:0], ss_n};
            scl_sync  <= {scl_sync[SYNC_STAGES-2:0], scl};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            dc_sync   <= {dc_sync[SYNC_STAGES-2:0], dc};
            prst_sync <= {prst_sync[SYNC_STAGES-2:0], oled_rst_n};
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!rst || panel_rst) begin
            scl_prev   <= 1'b0;
            bitcnt     <= '0;
            shift      <= '0;
            byte_valid <= 1'b0;
            rx_byte    <= '0;
            byte_dc    <= 1'b0;
        end else begin
            scl_prev   <= scl_s;
            byte_valid <= 1'b0;
            if (ss_n_s) begin
                bitcnt <= '0;
                shift  <= '0;
            end else if (scl_rise) begin
                shift  <= {shift[BYTE_W-3:0], mosi_s};
                bitcnt <= bitcnt + 3'd1;
                if (bitcnt == 3'd7) begin
                    byte_valid <= 1'b1;
                    rx_byte    <= {shift, mosi_s};
                    byte_dc    <= dc_s;
                end
            end
        end
    end

endmodule

// File: rtl/ssd1306_spi_ctrl.sv
// SSD1306 SPI front end: command decoder, GDDRAM pointer logic and display
// status registers feeding the frame buffer and renderer.
module ssd1306_spi_ctrl
    import ssd1306_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 sys_clk,
    input  logic                 rst,
    input  logic                 ss_n,
    input  logic                 scl,
    input  logic                 mosi,
    input  logic                 dc,
    input  logic                 oled_rst_n,
    output logic                 fb_we,
    output logic [FB_ADDR_W-1:0] fb_addr,
    output logic [BYTE_W-1:0]    fb_wdata,
    output logic                 display_on,
    output logic                 invert,
    output logic [BYTE_W-1:0]    contrast,
    output logic                 seg_remap,
    output logic                 com_flip
);

    logic              panel_rst;
    logic              byte_valid;
    logic [BYTE_W-1:0] rx_byte;
    logic              byte_dc;

    cmd_state_t        state;
    logic [BYTE_W-1:0] pend_op;
    addr_mode_t        mode;
    logic [COL_W-1:0]  col, col_start, col_end, col_nx;
    logic [PAGE_W-1:0] page, page_start, page_end, page_nx;

    ssd1306_spi_rx #(.SYNC_STAGES(SYNC_STAGES)) u_rx (
        .sys_clk    (sys_clk),
        .rst        (rst),
        .ss_n       (ss_n),
        .scl        (scl),
        .mosi       (mosi),
        .dc         (dc),
        .oled_rst_n (oled_rst_n),
        .panel_rst  (panel_rst),
        .byte_valid (byte_valid),
        .rx_byte    (rx_byte),
        .byte_dc    (byte_dc)
    );

    // Pointer position after a data write; wraps test equality with end only.
    always_comb begin
        col_nx  = col + 7'd1;
        page_nx = page;
        case (mode)
            MODE_HORIZ: begin
                if (col == col_end) begin
                    col_nx  = col_start;
                    page_nx = (page == page_end) ? page_start : page + 3'd1;
                end
            end
            MODE_VERT: begin
                col_nx = col;
                if (page == page_end) begin
                    page_nx = page_start;
                    col_nx  = (col == col_end) ? col_start : col + 7'd1;
                end else begin
                    page_nx = page + 3'd1;
                end
            end
            default: begin
                if (col == COL_MAX) col_nx = col_start;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!rst || panel_rst) begin
            fb_we      <= 1'b0;
            fb_addr    <= '0;
            fb_wdata   <= '0;
            display_on <= 1'b0;
            invert     <= 1'b0;
            contrast   <= CONTRAST_RST;
            seg_remap  <= 1'b0;
            com_flip   <= 1'b0;
            state      <= ST_IDLE;
            pend_op    <= '0;
            mode       <= MODE_PAGE;
            col_start  <= '0;
            col_end    <= COL_MAX;
            page_start <= '0;
            page_end   <= PAGE_MAX;
            col        <= '0;
            page       <= '0;
        end else begin
            fb_we <= 1'b0;
            if (byte_valid && byte_dc) begin
                // Data always wins: any half-received command is dropped.
                fb_we    <= 1'b1;
                fb_addr  <= {page, col};
                fb_wdata <= rx_byte;
                col      <= col_nx;
                page     <= page_nx;
                state    <= ST_IDLE;
            end else if (byte_valid) begin
                case (state)
                    ST_IDLE: begin
                        case (rx_byte) inside
                            OP_DISP_OFF, OP_DISP_ON: display_on <= rx_byte[0];
                            OP_INV_OFF, OP_INV_ON:   invert     <= rx_byte[0];
                            OP_SEG_0, OP_SEG_1:      seg_remap  <= rx_byte[0];
                            OP_COM_0:                com_flip   <= 1'b0;
                            OP_COM_1:                com_flip   <= 1'b1;
                            [8'hB0:8'hB7]:           page       <= rx_byte[2:0];
                            [8'h00:8'h0F]:           col[3:0]   <= rx_byte[3:0];
                            [8'h10:8'h17]:           col[6:4]   <= rx_byte[2:0];
                            OP_CONTRAST, OP_MODE, OP_COL_ADDR, OP_PAGE_ADDR: begin
                                pend_op <= rx_byte;
                                state   <= ST_ARG1;
                            end
                            OP_CHARGE, OP_MUX, OP_OFFSET, OP_CLKDIV,
                            OP_PRECHG, OP_COMPINS, OP_VCOMH: state <= ST_SKIP1;
                            default: ;
                        endcase
                    end
                    ST_ARG1: begin
                        state <= ST_IDLE;
                        case (pend_op)
                            OP_CONTRAST: contrast <= rx_byte;
                            OP_MODE: begin
                                if (rx_byte[1:0] != 2'd3) mode <= addr_mode_t'(rx_byte[1:0]);
                            end
                            OP_COL_ADDR: begin
                                col_start <= rx_byte[6:0];
                                col       <= rx_byte[6:0];
                                state     <= ST_ARG2;
                            end
                            OP_PAGE_ADDR: begin
                                page_start <= rx_byte[2:0];
                                page       <= rx_byte[2:0];
                                state      <= ST_ARG2;
                            end
                            default: ;
                        endcase
                    end
                    ST_ARG2: begin
                        if (pend_op == OP_COL_ADDR) col_end  <= rx_byte[6:0];
                        else                        page_end <= rx_byte[2:0];
                        state <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
